// File: rtl/histo_readout_seq_if.sv
// Outbound word stream from the histogram readout sequencer to the slow-control side.
// A word transfers on any rising edge where out_valid & out_ready are both high.
// Once raised, out_valid stays high with out_data/out_last stable until that transfer.
interface histo_readout_seq_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input  out_ready);
  modport slave  (input  out_data, input  out_valid, input  out_last, output out_ready);
endinterface

// File: rtl/histo_readout_seq.sv
// Steps the histogram bank channel index, waits for the bank to settle, freezes the
// channel's NHIST words and streams all NCH*NHIST words out, optionally clearing after.
module histo_readout_seq #(
  parameter int NCH        = 16,
  parameter int NHIST      = 8,
  parameter int SETTLE     = 3,
  parameter int CLR_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  clear_after,
  input  logic                  abort,
  input  logic [NHIST*32-1:0]   histos_in,
  output logic [7:0]            histostosend,
  output logic                  resethist,
  histo_readout_seq_if.master   stream,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);
  localparam int              KW      = (NHIST > 1) ? $clog2(NHIST) : 1;
  localparam logic [KW-1:0]   K_LAST  = KW'(NHIST - 1);
  localparam logic [7:0]      CH_LAST = 8'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_CLEAR   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           ch_q, ch_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 clr_q, clr_d;
  logic [NHIST*32-1:0]  buf_q, buf_d;
  logic                 hs;

  assign hs = stream.out_valid & stream.out_ready;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      k_q     <= '0;
      clr_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      k_q     <= k_d;
      clr_q   <= clr_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    k_d     = k_q;
    clr_d   = clr_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          clr_d   = clear_after;
          ch_d    = '0;
          cnt_d   = 8'(SETTLE);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        buf_d   = histos_in;
        k_d     = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
          if (k_q != K_LAST) begin
            k_d = k_q + 1'b1;
          end else if (ch_q != CH_LAST) begin
            ch_d    = ch_q + 8'd1;
            cnt_d   = 8'(SETTLE);
            state_d = S_SETTLE;
          end else if (clr_q) begin
            cnt_d   = 8'(CLR_CYCLES);
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = S_DONE;
      end
      S_DONE: begin
        ch_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort drops everything, including a pending clear, and parks the index at 0.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      ch_d    = '0;
    end
  end

  assign histostosend     = ch_q;
  assign stream.out_valid = (state_q == S_SEND);
  assign stream.out_data  = buf_q[{k_q, 5'b0} +: 32];
  assign stream.out_last  = (state_q == S_SEND) && (ch_q == CH_LAST) && (k_q == K_LAST);
  assign resethist        = (state_q == S_CLEAR);
  assign busy             = (state_q == S_SETTLE) || (state_q == S_CAPTURE) ||
                            (state_q == S_SEND)   || (state_q == S_CLEAR);
  assign done             = (state_q == S_DONE);
  assign dbg_state        = state_q;
endmodule

// File: doc/histo_readout_seq.md
Name: histo_readout_seq

Overview:
- Sequences readout of the trigger board's monitoring histograms (8 histograms × 16 channels, 32-bit each).
- The histogram bank presents one channel's 8 words at a time, selected by a registered index. This block steps that index, waits for the pipeline to settle, and freezes the 8 words.
- It then streams the words out through a valid/ready port to the slow-control/host side.
- Optionally, it pulses the histogram clear once the full readout completes.

Parameters:
- NCH, 16, number of channels stepped (index 0..NCH-1)
- NHIST, 8, words captured per channel
- SETTLE, 3, cycles waited after index change before capture (covers index re-register + histogram mux register); minimum 1
- CLR_CYCLES, 2, cycles resethist is held high

Ports:
- clk  in  1  single clock (ADC clock domain)
- nrst  in  1  synchronous active-low reset
- start  in  1  request a full readout; sampled only in IDLE
- clear_after  in  1  latched with start; 1 = pulse resethist after last word
- abort  in  1  synchronous abandon of the current readout
- histos_in  in  NHIST*32  word k in bits [32k+31:32k], for the channel currently selected
- histostosend  out  8  channel index driven to the histogram bank
- resethist  out  1  histogram clear strobe
- out_data  out  32  streamed histogram word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_last  out  1  high with the final word (ch NCH-1, k NHIST-1)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset (nrst=0 at an edge): state IDLE. All outputs are 0, including histostosend=0. Word buffer, channel counter, word counter and the latched clear flag are all 0. Reset overrides abort and start.
- FSM states: IDLE, SETTLE, CAPTURE, SEND, CLEAR, DONE.
- IDLE:
  - On start=1: latch clear_after, histostosend<=0, settle counter<=SETTLE, go to SETTLE.
  - busy goes 1 in the next cycle.
- SETTLE:
  - Decrement the counter each cycle.
  - After exactly SETTLE cycles in this state, go to CAPTURE.
- CAPTURE (1 cycle):
  - Buffer<=histos_in, word counter k<=0, go to SEND.
  - Later changes on histos_in do not affect the streamed data.
- SEND:
  - out_valid=1, out_data=buffer[k], out_last=(ch==NCH-1 && k==NHIST-1).
  - On a handshake with k<NHIST-1: k<=k+1.
  - On a handshake with k==NHIST-1 and ch<NCH-1: histostosend<=ch+1, settle counter<=SETTLE, go to SETTLE. out_valid is 0 next cycle.
  - On a handshake with the final word: go to CLEAR if the latched clear flag is set, else DONE.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable. out_valid never retracts except on abort or reset.
- CLEAR: resethist=1 for exactly CLR_CYCLES cycles, then DONE.
- DONE (1 cycle): done=1, busy=0, histostosend<=0, then IDLE.
- Timing with out_ready held high:
  - Start sampled at cycle 0; first out_valid at cycle SETTLE+2.
  - Each channel takes SETTLE+1+NHIST cycles.
  - Total stream is NCH*NHIST words, in channel-major order (ch0 k0..k7, ch1 k0..k7, ...).
- start while busy: ignored, not queued.
- abort=1 in any non-IDLE state: next cycle state IDLE, and out_valid, out_last, resethist, busy, done all 0, histostosend=0.
  - No done pulse is produced, and no clear is issued even if the clear flag is latched.
  - A partially sent stream is the consumer's to discard.
  - Aborting during CLEAR truncates the resethist pulse.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- Counters: ch is 8 bits and never exceeds NCH-1; k counts up to NHIST-1; no wrap occurs within one readout.

Test Plan:
- Full readout, SETTLE=3, out_ready=1, clear_after=0, histos_in = {ch,k} pattern (word = ch*256+k), start at cycle 0 →
  - first out_valid at cycle 5, ch c word 0 at cycle 5+12c;
  - 128 words in order, out_last only on word 127 (cycle 192);
  - done at cycle 193, busy 1→0 with done, resethist never high.
- Same run with clear_after=1 → resethist high at cycles 193–194 only, done at 195, histostosend=0 after.
- Backpressure: drop out_ready for 5 cycles while ch2 k3 is presented → out_data=0x0203 and out_valid held stable all 5 cycles; stream resumes with no loss or duplication (128 words total).
- Freeze: change histos_in to 0xFFFFFFFF one cycle after ch0 CAPTURE → all 8 ch0 words carry the pre-change values; ch1 sees the new values.
- Abort at ch7 k4 with clear_after=1 → next cycle out_valid=0, busy=0, histostosend=0; no done, no resethist. A new start 2 cycles later restarts from ch0 k0.
- Protocol edges:
  - start pulsed while busy → no effect;
  - start and abort together in IDLE → stays IDLE;
  - nrst low mid-SEND → all outputs 0 next cycle, and resethist stays 0.
